// File: rtl/lcd_wave_pkg.sv
// rtl/lcd_wave_pkg.sv - shared colours, channel palette and frame FSM states for lcd_wave_render
package lcd_wave_pkg;

  localparam logic [15:0] WHITE  = 16'hFFFF;
  localparam logic [15:0] YELLOW = 16'hFFE0;
  localparam logic [15:0] CYAN   = 16'h07FF;
  localparam logic [15:0] GREEN  = 16'h07E0;
  localparam logic [15:0] BLUE   = 16'h001F;

  localparam logic [15:0] CH_COLOR [4] = '{WHITE, YELLOW, CYAN, GREEN};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_SOF,
    ST_ACTIVE
  } frame_state_e;

endpackage

// File: rtl/lcd_wave_ch_xform.sv
// rtl/lcd_wave_ch_xform.sv - per-channel scale, shift, clamp and column-join register
module lcd_wave_ch_xform #(
  parameter int DATA_W   = 8,
  parameter int COORD_W  = 9,
  parameter int Y_OFFSET = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DATA_W-1:0]  d,
  input  logic [9:0]         v_shift,
  input  logic [4:0]         v_scale,
  input  logic               en,
  input  logic               load,
  input  logic [COORD_W-1:0] ypos,
  output logic [COORD_W-1:0] y,
  output logic [COORD_W-1:0] pre_y,
  output logic               hit
);

  localparam logic signed [12:0] MID_S  = 13'(1 << (DATA_W - 1));
  localparam logic signed [12:0] YOFF_S = 13'(Y_OFFSET);
  localparam logic signed [12:0] YMAX_S = 13'((1 << COORD_W) - 1);

  logic signed [12:0]  d_s, k_s, amt_s, s, y_s;
  logic [2:0]          sh;
  logic [COORD_W-1:0]  pre_y_d, pre_y_q;

  always_comb begin
    d_s   = $signed(13'(d));
    k_s   = $signed(13'(v_scale[3:0]));
    amt_s = $signed(13'(v_shift[8:0]));
    sh    = v_scale[3:1];
    // Both forms keep the mid-scale code MID fixed on screen while scaling around it.
    if (v_scale[4]) begin
      s = d_s * k_s - (MID_S * k_s - MID_S);
    end else begin
      s = $signed(13'(d >> sh)) + MID_S - (MID_S >>> sh);
    end
    if (v_shift[9]) begin
      y_s = s + YOFF_S + amt_s;
    end else begin
      y_s = s + YOFF_S - amt_s;
    end
    if (y_s < 13'sd0) begin
      y = '0;
    end else if (y_s > YMAX_S) begin
      y = '1;
    end else begin
      y = y_s[COORD_W-1:0];
    end
    pre_y_d = load ? y : pre_y_q;
    hit = en && (((ypos >= pre_y_q) && (ypos <= y)) || ((ypos >= y) && (ypos <= pre_y_q)));
  end

  assign pre_y = pre_y_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_y_q <= '0;
    end else begin
      pre_y_q <= pre_y_d;
    end
  end

endmodule

// File: rtl/lcd_wave_render.sv
// rtl/lcd_wave_render.sv - multi-channel waveform renderer over the UI layer; trigger line under LCD_WAVE_TRIG_LINE_EN
module lcd_wave_render
  import lcd_wave_pkg::*;
#(
  parameter int CH_NUM   = 2,
  parameter int DATA_W   = 8,
  parameter int COORD_W  = 9,
  parameter int X_START  = 49,
  parameter int X_END    = 349,
  parameter int Y_START  = 49,
  parameter int Y_END    = 250,
  parameter int Y_OFFSET = 20,
  parameter int RAM_LAT  = 1
) (
  input  logic                     lcd_pclk,
  input  logic                     rst,
  input  logic [COORD_W-1:0]       pixel_xpos,
  input  logic [COORD_W-1:0]       pixel_ypos,
  input  logic [15:0]              ui_pixel_data,
  input  logic [CH_NUM*DATA_W-1:0] wave_data,
  output logic [COORD_W-1:0]       wave_addr,
  output logic                     wave_data_req,
  input  logic                     outrange,
  input  logic [CH_NUM-1:0]        ch_en,
  input  logic [CH_NUM*10-1:0]     v_shift,
  input  logic [CH_NUM*5-1:0]      v_scale,
  input  logic [COORD_W-1:0]       trig_line,
  output logic                     wr_over,
  output logic [15:0]              pixel_data
);

  localparam logic [COORD_W-1:0] REQ_LO = COORD_W'(X_START - RAM_LAT);
  localparam logic [COORD_W-1:0] REQ_HI = COORD_W'(X_END - RAM_LAT);
  localparam logic [COORD_W-1:0] XS     = COORD_W'(X_START);
  localparam logic [COORD_W-1:0] XE     = COORD_W'(X_END);
  localparam logic [COORD_W-1:0] YS     = COORD_W'(Y_START);
  localparam logic [COORD_W-1:0] YE     = COORD_W'(Y_END);

  frame_state_e            state_d, state_q;
  logic                    wr_over_d, wr_over_q;
  logic                    outrange_d, outrange_q;
  logic [CH_NUM*10-1:0]    shift_d, shift_q;
  logic [CH_NUM*5-1:0]     scale_d, scale_q;
  logic [CH_NUM-1:0]       en_d, en_q;
  logic                    capture, sof, eof, y_in_win, load_en, draw_en;
  logic [CH_NUM-1:0]       ch_hit;
  logic [COORD_W-1:0]      unused_ch_y     [CH_NUM];
  logic [COORD_W-1:0]      unused_ch_pre_y [CH_NUM];

  always_comb begin
    y_in_win      = (pixel_ypos >= YS) && (pixel_ypos < YE);
    wave_data_req = y_in_win && (pixel_xpos >= REQ_LO) && (pixel_xpos < REQ_HI);
    wave_addr     = wave_data_req ? (pixel_xpos - REQ_LO) : '0;
    load_en       = y_in_win && (pixel_xpos >= XS) && (pixel_xpos < XE);
    draw_en       = y_in_win && (pixel_xpos > XS) && (pixel_xpos < XE);
    sof           = (pixel_xpos == '0) && (pixel_ypos == '0);
    eof           = (pixel_xpos == XE) && (pixel_ypos == YE);
  end

  always_comb begin
    state_d   = state_q;
    wr_over_d = 1'b0;
    capture   = 1'b0;
    case (state_q)
      ST_IDLE:     state_d = ST_WAIT_SOF;
      ST_WAIT_SOF: begin
        if (sof) begin
          state_d = ST_ACTIVE;
          capture = 1'b1;
        end
      end
      ST_ACTIVE: begin
        // A fresh SOF mid-frame means the previous frame was cut short.
        if (sof) begin
          capture = 1'b1;
        end else if (eof) begin
          state_d   = ST_WAIT_SOF;
          wr_over_d = 1'b1;
        end
      end
      default:     state_d = ST_IDLE;
    endcase
    shift_d    = capture ? v_shift : shift_q;
    scale_d    = capture ? v_scale : scale_q;
    en_d       = capture ? ch_en   : en_q;
    outrange_d = outrange;
  end

  always_ff @(posedge lcd_pclk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wr_over_q  <= 1'b0;
      outrange_q <= 1'b0;
      shift_q    <= '0;
      scale_q    <= '0;
      en_q       <= '0;
    end else begin
      state_q    <= state_d;
      wr_over_q  <= wr_over_d;
      outrange_q <= outrange_d;
      shift_q    <= shift_d;
      scale_q    <= scale_d;
      en_q       <= en_d;
    end
  end

  assign wr_over = wr_over_q;

`ifdef LCD_WAVE_TRIG_LINE_EN
  logic [COORD_W-1:0] trig_d, trig_q;

  always_comb trig_d = capture ? trig_line : trig_q;

  always_ff @(posedge lcd_pclk or posedge rst) begin
    if (rst) begin
      trig_q <= '0;
    end else begin
      trig_q <= trig_d;
    end
  end
`else
  logic unused_trig_line;
  assign unused_trig_line = ^trig_line;
`endif

  for (genvar n = 0; n < CH_NUM; n++) begin : g_ch
    lcd_wave_ch_xform #(
      .DATA_W   (DATA_W),
      .COORD_W  (COORD_W),
      .Y_OFFSET (Y_OFFSET)
    ) u_xform (
      .clk     (lcd_pclk),
      .rst     (rst),
      .d       (wave_data[n*DATA_W +: DATA_W]),
      .v_shift (shift_q[n*10 +: 10]),
      .v_scale (scale_q[n*5 +: 5]),
      .en      (en_q[n]),
      .load    (load_en),
      .ypos    (pixel_ypos),
      .y       (unused_ch_y[n]),
      .pre_y   (unused_ch_pre_y[n]),
      .hit     (ch_hit[n])
    );
  end

  always_comb begin
    pixel_data = ui_pixel_data;
    if (draw_en && !(outrange || outrange_q)) begin
      // Walk down so the lowest-index hitting channel is written last and wins.
      for (int n = CH_NUM - 1; n >= 0; n--) begin
        if (ch_hit[n]) begin
          pixel_data = CH_COLOR[n];
        end
      end
`ifdef LCD_WAVE_TRIG_LINE_EN
      if (!(|ch_hit) && (pixel_ypos == trig_q)) begin
        pixel_data = BLUE;
      end
`endif
    end
  end

endmodule

// File: tb/tb_lcd_wave_render.sv
// tb/tb_lcd_wave_render.sv - directed self-checking bench for lcd_wave_render
module tb_lcd_wave_render;
  import lcd_wave_pkg::*;

  localparam logic [15:0] UI = 16'h1234;

  logic        clk = 1'b0;
  logic        rst;
  logic [8:0]  xpos, ypos, trig_line;
  logic [15:0] ui_pixel_data, wave_data, pixel_data;
  logic [8:0]  wave_addr;
  logic        wave_data_req, outrange, wr_over;
  logic [1:0]  ch_en;
  logic [19:0] v_shift;
  logic [9:0]  v_scale;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lcd_wave_render dut (
    .lcd_pclk      (clk),
    .rst           (rst),
    .pixel_xpos    (xpos),
    .pixel_ypos    (ypos),
    .ui_pixel_data (ui_pixel_data),
    .wave_data     (wave_data),
    .wave_addr     (wave_addr),
    .wave_data_req (wave_data_req),
    .outrange      (outrange),
    .ch_en         (ch_en),
    .v_shift       (v_shift),
    .v_scale       (v_scale),
    .trig_line     (trig_line),
    .wr_over       (wr_over),
    .pixel_data    (pixel_data)
  );

  task automatic drive(input int x, input int y, input logic [7:0] d0, input logic [7:0] d1);
    @(posedge clk);
    #1;
    xpos      = 9'(x);
    ypos      = 9'(y);
    wave_data = {d1, d0};
    #2;
  endtask

  task automatic pair(input int x, input int row, input logic [7:0] a0, input logic [7:0] b0,
                      input logic [7:0] a1, input logic [7:0] b1);
    drive(x - 1, row, a0, a1);
    drive(x, row, b0, b1);
  endtask

  task automatic sof();
    drive(0, 0, 8'd0, 8'd0);
    drive(0, 0, 8'd0, 8'd0);
    drive(1, 0, 8'd0, 8'd0);
  endtask

  task automatic test_reset();
    int xs [7];
    int ys [7];
    logic       rq [7];
    logic [8:0] ad [7];
    xs = '{48, 47, 347, 348, 100, 100, 100};
    ys = '{100, 100, 100, 100, 48, 249, 250};
    rq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    ad = '{9'd0, 9'd0, 9'd299, 9'd0, 9'd0, 9'd52, 9'd0};
    rst = 1'b1;
    drive(10, 10, 8'd128, 8'd128);
    n_checks++;
    if (wr_over !== 1'b0) begin n_fail++; $display("FAIL reset_wr_over got %b exp 0", wr_over); end
    n_checks++;
    if (dut.state_q !== ST_IDLE) begin n_fail++; $display("FAIL reset_state got %0d exp %0d", dut.state_q, ST_IDLE); end
    n_checks++;
    if (pixel_data !== UI) begin n_fail++; $display("FAIL outside_ui got %h exp %h", pixel_data, UI); end
    for (int i = 0; i < 7; i++) begin
      drive(xs[i], ys[i], 8'd0, 8'd0);
      n_checks++;
      if (wave_data_req !== rq[i] || wave_addr !== ad[i]) begin
        n_fail++;
        $display("FAIL req x=%0d y=%0d got req=%b addr=%0d exp req=%b addr=%0d",
                 xs[i], ys[i], wave_data_req, wave_addr, rq[i], ad[i]);
      end
    end
    rst = 1'b0;
    sof();
    n_checks++;
    if (dut.state_q !== ST_ACTIVE) begin n_fail++; $display("FAIL sof_state got %0d exp %0d", dut.state_q, ST_ACTIVE); end
    drive(349, 250, 8'd0, 8'd0);
    drive(5, 5, 8'd0, 8'd0);
    rst = 1'b1;
    #1;
    n_checks++;
    if (wr_over !== 1'b0) begin n_fail++; $display("FAIL midframe_rst_wr_over got %b exp 0", wr_over); end
    n_checks++;
    if (dut.state_q !== ST_IDLE) begin n_fail++; $display("FAIL midframe_rst_state got %0d exp %0d", dut.state_q, ST_IDLE); end
    rst = 1'b0;
    pair(201, 148, 8'd128, 8'd128, 8'd128, 8'd128);
    n_checks++;
    if (pixel_data !== UI) begin n_fail++; $display("FAIL post_rst_shadow got %h exp %h", pixel_data, UI); end
    sof();
    pair(201, 148, 8'd128, 8'd128, 8'd128, 8'd128);
    n_checks++;
    if (pixel_data !== WHITE) begin n_fail++; $display("FAIL post_sof_trace got %h exp %h", pixel_data, WHITE); end
  endtask

  task automatic test_frame_end();
    sof();
    drive(349, 250, 8'd0, 8'd0);
    n_checks++;
    if (wr_over !== 1'b0) begin n_fail++; $display("FAIL wr_over_early got %b exp 0", wr_over); end
    drive(0, 5, 8'd0, 8'd0);
    n_checks++;
    if (wr_over !== 1'b1) begin n_fail++; $display("FAIL wr_over_pulse got %b exp 1", wr_over); end
    drive(1, 5, 8'd0, 8'd0);
    n_checks++;
    if (wr_over !== 1'b0) begin n_fail++; $display("FAIL wr_over_width got %b exp 0", wr_over); end
    drive(349, 250, 8'd0, 8'd0);
    drive(0, 5, 8'd0, 8'd0);
    n_checks++;
    if (wr_over !== 1'b0) begin n_fail++; $display("FAIL wr_over_idle got %b exp 0", wr_over); end
  endtask

  task automatic test_join();
    int rows [5];
    logic [15:0] exp;
    rows = '{119, 120, 145, 170, 171};
    v_scale = 10'h011;
    sof();
    for (int i = 0; i < 5; i++) begin
      pair(201, rows[i], 8'd100, 8'd150, 8'd0, 8'd0);
      exp = (rows[i] >= 120 && rows[i] <= 170) ? WHITE : UI;
      n_checks++;
      if (pixel_data !== exp) begin n_fail++; $display("FAIL join row=%0d got %h exp %h", rows[i], pixel_data, exp); end
    end
    pair(201, 145, 8'd150, 8'd100, 8'd0, 8'd0);
    n_checks++;
    if (pixel_data !== WHITE) begin n_fail++; $display("FAIL join_rev_in got %h exp %h", pixel_data, WHITE); end
    pair(201, 171, 8'd150, 8'd100, 8'd0, 8'd0);
    n_checks++;
    if (pixel_data !== UI) begin n_fail++; $display("FAIL join_rev_out got %h exp %h", pixel_data, UI); end
    v_scale = 10'h000;
  endtask

  task automatic test_priority();
    ch_en = 2'b11;
    sof();
    pair(201, 148, 8'd128, 8'd128, 8'd128, 8'd128);
    n_checks++;
    if (pixel_data !== WHITE) begin n_fail++; $display("FAIL prio_both got %h exp %h", pixel_data, WHITE); end
    ch_en = 2'b10;
    pair(201, 148, 8'd128, 8'd128, 8'd128, 8'd128);
    n_checks++;
    if (pixel_data !== WHITE) begin n_fail++; $display("FAIL prio_shadowed got %h exp %h", pixel_data, WHITE); end
    sof();
    pair(201, 148, 8'd128, 8'd128, 8'd128, 8'd128);
    n_checks++;
    if (pixel_data !== YELLOW) begin n_fail++; $display("FAIL prio_ch1 got %h exp %h", pixel_data, YELLOW); end
    ch_en = 2'b01;
    sof();
  endtask

  task automatic test_shadow();
    pair(201, 148, 8'd128, 8'd128, 8'd0, 8'd0);
    n_checks++;
    if (pixel_data !== WHITE) begin n_fail++; $display("FAIL shadow_base got %h exp %h", pixel_data, WHITE); end
    v_shift = 20'h0020A;
    pair(201, 148, 8'd128, 8'd128, 8'd0, 8'd0);
    n_checks++;
    if (pixel_data !== WHITE) begin n_fail++; $display("FAIL shadow_hold got %h exp %h", pixel_data, WHITE); end
    pair(201, 158, 8'd128, 8'd128, 8'd0, 8'd0);
    n_checks++;
    if (pixel_data !== UI) begin n_fail++; $display("FAIL shadow_hold_new got %h exp %h", pixel_data, UI); end
    sof();
    pair(201, 158, 8'd128, 8'd128, 8'd0, 8'd0);
    n_checks++;
    if (pixel_data !== WHITE) begin n_fail++; $display("FAIL shadow_moved got %h exp %h", pixel_data, WHITE); end
    pair(201, 148, 8'd128, 8'd128, 8'd0, 8'd0);
    n_checks++;
    if (pixel_data !== UI) begin n_fail++; $display("FAIL shadow_old got %h exp %h", pixel_data, UI); end
    v_shift = 20'h0;
    sof();
  endtask

  task automatic test_scale();
    v_scale = 10'h012;
    sof();
    pair(201, 168, 8'd138, 8'd138, 8'd0, 8'd0);
    n_checks++;
    if (pixel_data !== WHITE) begin n_fail++; $display("FAIL enlarge2 got %h exp %h", pixel_data, WHITE); end
    pair(201, 158, 8'd138, 8'd138, 8'd0, 8'd0);
    n_checks++;
    if (pixel_data !== UI) begin n_fail++; $display("FAIL enlarge2_off got %h exp %h", pixel_data, UI); end
    v_scale = 10'h004;
    sof();
    pair(201, 166, 8'd200, 8'd200, 8'd0, 8'd0);
    n_checks++;
    if (pixel_data !== WHITE) begin n_fail++; $display("FAIL shrink4 got %h exp %h", pixel_data, WHITE); end
    pair(201, 167, 8'd200, 8'd200, 8'd0, 8'd0);
    n_checks++;
    if (pixel_data !== UI) begin n_fail++; $display("FAIL shrink4_off got %h exp %h", pixel_data, UI); end
    v_scale = 10'h0;
  endtask

  task automatic test_clamp_outrange();
    int rows [3];
    logic [15:0] exps [3];
    rows = '{60, 103, 104};
    exps = '{WHITE, WHITE, UI};
    v_shift = 20'h0012C;
    sof();
    pair(201, 148, 8'd128, 8'd128, 8'd0, 8'd0);
    n_checks++;
    if (pixel_data !== UI) begin n_fail++; $display("FAIL up300_hidden got %h exp %h", pixel_data, UI); end
    v_scale = 10'h01F;
    sof();
    for (int i = 0; i < 3; i++) begin
      pair(201, rows[i], 8'd128, 8'd145, 8'd0, 8'd0);
      n_checks++;
      if (pixel_data !== exps[i]) begin n_fail++; $display("FAIL clamp_low row=%0d got %h exp %h", rows[i], pixel_data, exps[i]); end
    end
    pair(201, 230, 8'd255, 8'd145, 8'd0, 8'd0);
    n_checks++;
    if (pixel_data !== WHITE) begin n_fail++; $display("FAIL clamp_high got %h exp %h", pixel_data, WHITE); end
    v_scale = 10'h0;
    v_shift = 20'h0;
    sof();
    pair(201, 148, 8'd128, 8'd128, 8'd0, 8'd0);
    outrange = 1'b1;
    #1;
    n_checks++;
    if (pixel_data !== UI) begin n_fail++; $display("FAIL outrange_now got %h exp %h", pixel_data, UI); end
    drive(202, 148, 8'd128, 8'd0);
    outrange = 1'b0;
    #1;
    n_checks++;
    if (pixel_data !== UI) begin n_fail++; $display("FAIL outrange_delayed got %h exp %h", pixel_data, UI); end
    drive(203, 148, 8'd128, 8'd0);
    n_checks++;
    if (pixel_data !== WHITE) begin n_fail++; $display("FAIL outrange_clear got %h exp %h", pixel_data, WHITE); end
  endtask

  task automatic test_trig_boundary();
    logic [15:0] exp_trig;
`ifdef LCD_WAVE_TRIG_LINE_EN
    exp_trig = BLUE;
`else
    exp_trig = UI;
`endif
    trig_line = 9'd100;
    sof();
    pair(201, 100, 8'd128, 8'd128, 8'd0, 8'd0);
    n_checks++;
    if (pixel_data !== exp_trig) begin n_fail++; $display("FAIL trig_row got %h exp %h", pixel_data, exp_trig); end
    pair(201, 101, 8'd128, 8'd128, 8'd0, 8'd0);
    n_checks++;
    if (pixel_data !== UI) begin n_fail++; $display("FAIL trig_next got %h exp %h", pixel_data, UI); end
    trig_line = 9'd148;
    sof();
    pair(201, 148, 8'd128, 8'd128, 8'd0, 8'd0);
    n_checks++;
    if (pixel_data !== WHITE) begin n_fail++; $display("FAIL trig_under_trace got %h exp %h", pixel_data, WHITE); end
    trig_line = 9'd0;
    pair(49, 148, 8'd128, 8'd128, 8'd0, 8'd0);
    n_checks++;
    if (pixel_data !== UI) begin n_fail++; $display("FAIL x_start_edge got %h exp %h", pixel_data, UI); end
    pair(348, 148, 8'd128, 8'd128, 8'd0, 8'd0);
    n_checks++;
    if (pixel_data !== WHITE) begin n_fail++; $display("FAIL x_last_col got %h exp %h", pixel_data, WHITE); end
    drive(349, 148, 8'd128, 8'd0);
    n_checks++;
    if (pixel_data !== UI) begin n_fail++; $display("FAIL x_end_edge got %h exp %h", pixel_data, UI); end
  endtask

  initial begin
    rst           = 1'b1;
    xpos          = '0;
    ypos          = '0;
    ui_pixel_data = UI;
    wave_data     = '0;
    outrange      = 1'b0;
    ch_en         = 2'b01;
    v_shift       = '0;
    v_scale       = '0;
    trig_line     = '0;
    test_reset();
    test_frame_end();
    test_join();
    test_priority();
    test_shadow();
    test_scale();
    test_clamp_outrange();
    test_trig_boundary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
